// File: rtl/bool_lut_eval.sv
// Programmable Boolean function unit.
// NOUT functions of NIN variables are held as a truth table and evaluated
// with one cycle of registered latency. A scan engine walks every minterm
// and reports the on-set size of each function.
module bool_lut_eval #(
  parameter int NIN  = 4,
  parameter int NOUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [NIN-1:0]         cfg_addr,
  input  logic [NOUT-1:0]        cfg_data,
  output logic                   cfg_ready,
  input  logic                   in_valid,
  input  logic [NIN-1:0]         in_vars,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [NOUT-1:0]        out_f,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NOUT*(NIN+1)-1:0] cnt
);

  localparam int DEPTH = 2 ** NIN;
  // One extra bit so a constant-1 function (count = DEPTH) never wraps.
  localparam int CW = NIN + 1;
  localparam logic [NIN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q;
  logic [NOUT-1:0]      tbl_q [DEPTH];
  logic [NIN-1:0]       idx_q;
  logic [NOUT*CW-1:0]   cnt_q;
  logic [NOUT*CW-1:0]   cnt_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 out_valid_q;
  logic [NOUT-1:0]      out_f_q;
  logic                 idle;

  // Adds a single minterm bit to an on-set counter.
  function automatic logic [CW-1:0] add_bit(input logic [CW-1:0] acc, input logic b);
    return acc + CW'(b);
  endfunction

  // Writes and evaluations are only accepted while the scan engine is idle.
  assign idle      = (state_q == IDLE);
  assign cfg_ready = idle;
  assign in_ready  = idle;

  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt       = cnt_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;

  // Next counter values: each slice accumulates its bit of the current row.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NOUT; k++) begin
      cnt_d[k*CW +: CW] = add_bit(cnt_q[k*CW +: CW], tbl_q[idx_q][k]);
    end
  end

  // Scan FSM: clears counters on start, accumulates one row per cycle,
  // stops on the terminal index and pulses done for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          cnt_q <= cnt_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Truth table storage; cleared by reset, written one row at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we && idle) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Evaluation register; a same-edge write to the same row is not seen here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
    end else begin
      out_valid_q <= in_valid && idle;
      if (in_valid && idle) begin
        out_f_q <= tbl_q[in_vars];
      end
    end
  end

endmodule
